// File: rtl/shift_arbiter_if.sv
// One requester's view of the shift arbiter: an operation request
// channel and the matching result handshake.
interface shift_arbiter_if #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
);
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_data;
   logic [SHW-1:0]   req_amount;
   logic [1:0]       req_sel;
   logic             rsp_valid;
   logic             rsp_ready;

   modport master (
      output req_valid,
      output req_data,
      output req_amount,
      output req_sel,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid
   );

   modport slave (
      input  req_valid,
      input  req_data,
      input  req_amount,
      input  req_sel,
      input  rsp_ready,
      output req_ready,
      output rsp_valid
   );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one external combinational shifter between
// two requesters; one operation in flight, registered operands/result.
module shift_arbiter #(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   shift_arbiter_if.slave   req0,
   shift_arbiter_if.slave   req1,
   output logic [WIDTH-1:0] rsp_result,
   output logic [WIDTH-1:0] sh_data,
   output logic [SHW-1:0]   sh_amount,
   output logic [1:0]       sh_sel,
   input  logic [WIDTH-1:0] sh_result
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [SHW-1:0]   amount_q, amount_d;
   logic [1:0]       sel_q, sel_d;
   logic             owner_q, owner_d;
   logic             last_q, last_d;

   logic grant0;
   logic grant1;
   logic accept;
   logic rsp_done;

   // last_q names the previous winner; ties go to the other port
   assign grant0 = req0.req_valid
                 & (~req1.req_valid | last_q);
   assign grant1 = req1.req_valid
                 & (~req0.req_valid | ~last_q);

   assign accept   = (state_q == IDLE)
                   & (grant0 | grant1);
   assign rsp_done = owner_q ? req1.rsp_ready
                             : req0.rsp_ready;

   // operand regs only move on accept, so sh_* hold outside EXEC
   assign sh_data    = data_q;
   assign sh_amount  = amount_q;
   assign sh_sel     = sel_q;
   assign rsp_result = result_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (grant0 | grant1) state_d = EXEC;
         EXEC: state_d = RESP;
         RESP: if (rsp_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req0.req_ready = 1'b0;
      req1.req_ready = 1'b0;
      req0.rsp_valid = 1'b0;
      req1.rsp_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            req0.req_ready = grant0;
            req1.req_ready = grant1;
         end
         RESP: begin
            req0.rsp_valid = ~owner_q;
            req1.rsp_valid = owner_q;
         end
         default: ;
      endcase
   end

   always_comb begin
      data_d   = data_q;
      amount_d = amount_q;
      sel_d    = sel_q;
      owner_d  = owner_q;
      last_d   = last_q;
      result_d = result_q;
      if (accept) begin
         data_d   = grant1 ? req1.req_data
                           : req0.req_data;
         amount_d = grant1 ? req1.req_amount
                           : req0.req_amount;
         sel_d    = grant1 ? req1.req_sel
                           : req0.req_sel;
         owner_d  = grant1;
         last_d   = grant1;
      end
      if (state_q == EXEC) begin
         result_d = sh_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= '0;
         amount_q <= '0;
         sel_q    <= '0;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         result_q <= '0;
      end else begin
         data_q   <= data_d;
         amount_q <= amount_d;
         sel_q    <= sel_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         result_q <= result_d;
      end
   end

endmodule
